serial_pattern_tx: RTL and testbench
====================================

# serial_pattern_tx

- Serializes a loaded bit pattern onto a single-bit line `w`, LSB first, one bit per clock.
- Inserts an idle gap of zeros after each pattern.
- Drives the `w` input of the Moore/Mealy consecutive-ones detector FSM and any other serial-bit consumer in the lab designs.
- Accepts patterns over a valid/ready handshake and flags completion with a one-cycle `done` pulse.

## Interface

Parameters:
- `WIDTH`, default 8: maximum pattern length in bits; must be ≥ 2.
- `GAP_CYCLES`, default 2: number of forced-zero cycles after each pattern; 0 is legal.
- `LW`, derived as $clog2(WIDTH)+1: width of the length field.

Ports:
- `clock`  in  1: single clock, all logic on posedge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: pattern offered.
- `in_ready`  out  1: block can accept; equals (state==IDLE) & ~rst.
- `in_data`  in  WIDTH: pattern; bit 0 is transmitted first.
- `in_len`  in  LW: number of bits to send.
- `in_repeat`  in  4: extra repetitions; present only with `SERIAL_TX_REPEAT_EN`.
- `w`  out  1: serial bit, registered.
- `w_valid`  out  1: high while `w` carries a pattern bit, registered.
- `busy`  out  1: state != IDLE.
- `done`  out  1: one-cycle completion pulse, registered.

## Operation

States (shared enum):
- IDLE
  - `in_ready`=1, `w`=0, `w_valid`=0.
  - Accept when `in_valid` & `in_ready`; latch `in_data` into the shift register and the pattern store.
  - `in_len` 0: accepted and dropped; no bits are sent; `done` pulses in the next cycle; state stays IDLE.
  - `in_len` > WIDTH: clamped to WIDTH.
  - Otherwise go to SHIFT with bit counter = len.
- SHIFT
  - Each cycle: `w` = sreg[0], `w_valid`=1, shift right with zero fill, decrement the counter.
  - After the last bit: go to GAP if GAP_CYCLES > 0, else end-of-pass.
- GAP
  - `w`=0, `w_valid`=0 for exactly GAP_CYCLES cycles, then end-of-pass.
- End-of-pass
  - Repeat counter nonzero: decrement it, reload sreg from the pattern store, return to SHIFT with no extra cycle.
  - Otherwise: go to IDLE and assert `done` for that first IDLE cycle.

Other rules:
- `in_data`/`in_len` are ignored outside IDLE.
- `in_valid` may drop at any time without harm.
- Reset mid-operation:
  - All state clears immediately.
  - Outputs go to reset values.
  - The partial pattern is lost and no `done` is issued.
- Reset values: `w`=0, `w_valid`=0, `done`=0, `busy`=0, `in_ready`=0 while `rst` is high, state=IDLE, counters=0.

## Timing

- Handshake accepted at edge k: bit i appears on `w` in cycle k+1+i, for i = 0..L-1.
- Gap occupies cycles k+L+1 .. k+L+GAP_CYCLES.
- `done` and `in_ready` are both high in cycle k+L+GAP_CYCLES+1.
  - A new pattern may be accepted in that same cycle, so `done` coincides with the acceptance.
  - Sustained throughput: one pattern per L+GAP_CYCLES+1 cycles.
- With repeat R: total active span is (R+1)·(L+GAP_CYCLES) cycles after acceptance; `done` follows in the next cycle.
- No combinational path from inputs to `w`, `w_valid` or `done`.
- `in_ready` depends only on state and `rst`.

## Configuration

- `SERIAL_TX_REPEAT_EN` defined:
  - `in_repeat` port exists, latched on acceptance.
  - Pattern is sent `in_repeat`+1 times, each pass followed by its gap.
- Not defined:
  - Port absent, repeat logic removed.
  - Exactly one pass per acceptance.

## Structure

- Package `serial_tx_pkg` holds:
  - `tx_state_t` enum {IDLE, SHIFT, GAP}.
  - Localparam function computing LW from WIDTH.
  - Default GAP_CYCLES constant.
- Sub-module `tx_down_counter`: loadable down-counter with zero flag, parameterized width.
  - One instance for the bit count, one for the gap count.
  - Repeat count uses a third instance when enabled.

## Test plan

- Reset then accept 8'hFF, len 8 → `w`=1 for 8 cycles starting one cycle after acceptance, 2 gap zeros, `done` pulse. The detector's Moore count output asserts once its run threshold is reached.
- Accept 8'b0000_0101, len 3 → `w` sequence 1,0,1 with `w_valid` high for exactly 3 cycles; `done` at acceptance+6.
- Accept len 0, then len 12 with WIDTH 8 → first produces `done` only with `w_valid` never high; second sends exactly 8 bits.
- Hold `in_valid` high with back-to-back patterns → second acceptance occurs in the `done` cycle of the first, with no idle cycle beyond the gap.
- Assert `rst` in the 4th bit of an 8-bit pattern → `w`/`w_valid`/`busy` go 0 immediately with no `done`; after release a new pattern transmits correctly.
- With `SERIAL_TX_REPEAT_EN`, 8'b11, len 2, repeat 2 → pattern 1,1,gap,gap repeated 3 times; single `done` at acceptance+13.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Holds the state enum, the default gap length and the length-field width helper.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } tx_state_t;

  localparam int GAP_CYCLES_DEF = 2;

  // Length field must hold WIDTH itself, hence the +1.
  function automatic int calc_lw(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/tx_down_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
// Ports: i_load/i_load_val reload, i_dec decrements, o_zero flags count==0.
module tx_down_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serializes a pattern LSB first on w, followed by GAP_CYCLES forced zeros.
// Ports: in_* valid/ready pattern input, w/w_valid serial out, busy, done pulse.
// Optional SERIAL_TX_REPEAT_EN adds in_repeat (extra passes per pattern).
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int LW         = calc_lw(WIDTH)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LW-1:0]    in_len,
`ifdef SERIAL_TX_REPEAT_EN
  input  logic [3:0]       in_repeat,
`endif
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done
);

  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [LW-1:0] LMAX = LW'(WIDTH);

  tx_state_t        r_state, w_st_nxt;
  logic [WIDTH-1:0] r_sreg, w_sreg_nxt;
  logic             w_w_nxt, w_wv_nxt, w_done_nxt;
  logic             w_accept, w_eop;
  logic [LW-1:0]    w_len;
  logic             w_bit_ld, w_bit_dec, w_bit_zero;
  logic [LW-1:0]    w_bit_val;
  logic             w_gap_ld, w_gap_dec, w_gap_zero;

`ifdef SERIAL_TX_REPEAT_EN
  logic [WIDTH-1:0] r_store;
  logic [LW-1:0]    r_len;
  logic             w_store_ld, w_rep_ld, w_rep_dec, w_rep_zero;
`endif

  assign in_ready = (r_state == IDLE) & ~rst;
  assign busy     = (r_state != IDLE);
  assign w_accept = in_valid & in_ready;
  assign w_len    = (in_len > LMAX) ? LMAX : in_len;

  // Bit counter holds the bits still to show after the one on w.
  tx_down_counter #(.W(LW)) u_bit_cnt (
    .clock      (clock),
    .rst        (rst),
    .i_load     (w_bit_ld),
    .i_load_val (w_bit_val),
    .i_dec      (w_bit_dec),
    .o_zero     (w_bit_zero)
  );

  tx_down_counter #(.W(GW)) u_gap_cnt (
    .clock      (clock),
    .rst        (rst),
    .i_load     (w_gap_ld),
    .i_load_val (GAP_LOAD),
    .i_dec      (w_gap_dec),
    .o_zero     (w_gap_zero)
  );

`ifdef SERIAL_TX_REPEAT_EN
  tx_down_counter #(.W(4)) u_rep_cnt (
    .clock      (clock),
    .rst        (rst),
    .i_load     (w_rep_ld),
    .i_load_val (in_repeat),
    .i_dec      (w_rep_dec),
    .o_zero     (w_rep_zero)
  );
`endif

  always_comb begin
    w_st_nxt   = r_state;
    w_sreg_nxt = r_sreg;
    w_w_nxt    = 1'b0;
    w_wv_nxt   = 1'b0;
    w_done_nxt = 1'b0;
    w_bit_ld   = 1'b0;
    w_bit_val  = '0;
    w_bit_dec  = 1'b0;
    w_gap_ld   = 1'b0;
    w_gap_dec  = 1'b0;
    w_eop      = 1'b0;
`ifdef SERIAL_TX_REPEAT_EN
    w_store_ld = 1'b0;
    w_rep_ld   = 1'b0;
    w_rep_dec  = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_len == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            // Bit 0 goes out on the accept edge itself.
            w_st_nxt   = SHIFT;
            w_sreg_nxt = in_data >> 1;
            w_w_nxt    = in_data[0];
            w_wv_nxt   = 1'b1;
            w_bit_ld   = 1'b1;
            w_bit_val  = w_len - LW'(1);
`ifdef SERIAL_TX_REPEAT_EN
            w_store_ld = 1'b1;
            w_rep_ld   = 1'b1;
`endif
          end
        end
      end
      SHIFT: begin
        if (!w_bit_zero) begin
          w_bit_dec  = 1'b1;
          w_sreg_nxt = r_sreg >> 1;
          w_w_nxt    = r_sreg[0];
          w_wv_nxt   = 1'b1;
        end else if (GAP_CYCLES > 0) begin
          w_st_nxt = GAP;
          w_gap_ld = 1'b1;
        end else begin
          w_eop = 1'b1;
        end
      end
      GAP: begin
        if (!w_gap_zero) w_gap_dec = 1'b1;
        else             w_eop     = 1'b1;
      end
      default: w_st_nxt = IDLE;
    endcase

    if (w_eop) begin
`ifdef SERIAL_TX_REPEAT_EN
      if (!w_rep_zero) begin
        // Next pass starts without a bubble.
        w_rep_dec  = 1'b1;
        w_st_nxt   = SHIFT;
        w_sreg_nxt = r_store >> 1;
        w_w_nxt    = r_store[0];
        w_wv_nxt   = 1'b1;
        w_bit_ld   = 1'b1;
        w_bit_val  = r_len - LW'(1);
      end else begin
        w_st_nxt   = IDLE;
        w_done_nxt = 1'b1;
      end
`else
      w_st_nxt   = IDLE;
      w_done_nxt = 1'b1;
`endif
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      w       <= 1'b0;
      w_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_st_nxt;
      r_sreg  <= w_sreg_nxt;
      w       <= w_w_nxt;
      w_valid <= w_wv_nxt;
      done    <= w_done_nxt;
    end
  end

`ifdef SERIAL_TX_REPEAT_EN
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_store <= '0;
      r_len   <= '0;
    end else if (w_store_ld) begin
      r_store <= in_data;
      r_len   <= w_len;
    end
  end
`endif

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: drivers push expected bits and
// done pulses with their cycle numbers, a monitor pops and compares them.
module tb_serial_pattern_tx;

  localparam int WIDTH = 8;
  localparam int GAP   = 2;
  localparam int LW    = $clog2(WIDTH) + 1;

  typedef struct {
    int cyc;
    bit val;
  } ev_t;

  logic             clock = 1'b0;
  logic             rst   = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data  = '0;
  logic [LW-1:0]    in_len   = '0;
`ifdef SERIAL_TX_REPEAT_EN
  logic [3:0]       in_repeat = '0;
`endif
  logic             w, w_valid, busy, done;

  int  cyc   = 0;
  int  n_chk = 0;
  int  n_err = 0;
  ev_t bq[$];
  int  dq[$];
  ev_t ev;
  int  dc;

  serial_pattern_tx #(
    .WIDTH      (WIDTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
`ifdef SERIAL_TX_REPEAT_EN
    .in_repeat (in_repeat),
`endif
    .w         (w),
    .w_valid   (w_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Monitor: compares every presented bit and done pulse with the queues.
  always @(negedge clock) begin
    if (!rst) begin
      n_chk++;
      if (w_valid) begin
        if (bq.size() == 0) begin
          n_err++;
          $display("FAIL bit: unexpected w=%0b at cycle %0d", w, cyc);
        end else begin
          ev = bq.pop_front();
          if (ev.cyc != cyc || ev.val != w) begin
            n_err++;
            $display("FAIL bit: got w=%0b at cycle %0d expected %0b at %0d",
                     w, cyc, ev.val, ev.cyc);
          end
        end
      end else if (w !== 1'b0) begin
        n_err++;
        $display("FAIL idle_w: got w=%0b at cycle %0d expected 0", w, cyc);
      end
      if (done) begin
        n_chk++;
        if (dq.size() == 0) begin
          n_err++;
          $display("FAIL done: unexpected pulse at cycle %0d", cyc);
        end else begin
          dc = dq.pop_front();
          if (dc != cyc) begin
            n_err++;
            $display("FAIL done: got cycle %0d expected %0d", cyc, dc);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [WIDTH-1:0] d, input int l,
                      input int r, input bit keep, output int acc);
    int L;
    int t;
    in_data  = d;
    in_len   = LW'(l);
`ifdef SERIAL_TX_REPEAT_EN
    in_repeat = 4'(r);
`endif
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    acc = cyc;
    if (!in_ready) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    L = (l > WIDTH) ? WIDTH : l;
    if (L == 0) begin
      dq.push_back(acc + 1);
    end else begin
      for (int p = 0; p <= r; p++)
        for (int i = 0; i < L; i++)
          bq.push_back('{acc + 1 + p * (L + GAP) + i, d[i]});
      dq.push_back(acc + (r + 1) * (L + GAP) + 1);
    end
    @(negedge clock);
    if (!keep) in_valid = 1'b0;
  endtask

  initial begin
    int a1, a2;
    #12;
    chk("rst_w", int'(w), 0);
    chk("rst_w_valid", int'(w_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    @(negedge clock);
    #1 rst = 1'b0;
    @(negedge clock);
    chk("idle_in_ready", int'(in_ready), 1);

    send(8'hFF, 8, 0, 0, a1);
    chk("busy_shift", int'(busy), 1);
    send(8'b0000_0101, 3, 0, 0, a1);
    send(8'h5A, 0, 0, 0, a1);
    send(8'hA5, 12, 0, 0, a1);

    send(8'h3C, 4, 0, 1, a1);
    send(8'hC3, 5, 0, 0, a2);
    chk("b2b_accept", a2, a1 + 4 + GAP + 1);

    send(8'hB6, 8, 0, 0, a1);
    while (cyc < a1 + 4) @(negedge clock);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_w", int'(w), 0);
    chk("mid_rst_w_valid", int'(w_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    bq.delete();
    dq.delete();
    repeat (3) @(negedge clock);
    #1 rst = 1'b0;
    @(negedge clock);
    send(8'h69, 8, 0, 0, a1);

`ifdef SERIAL_TX_REPEAT_EN
    send(8'b11, 2, 2, 0, a1);
`endif

    for (int t = 0; t < 300 && (bq.size() != 0 || dq.size() != 0); t++)
      @(negedge clock);
    repeat (5) @(negedge clock);
    chk("bits_left", bq.size(), 0);
    chk("dones_left", dq.size(), 0);
    chk("end_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
